ptw_arbiter: RTL and testbench

PTW_ARBITER -- requirements
Module: ptw_arbiter

---
 rtl/ptw_arb_pkg.sv | 20 ++
 rtl/ptw_arbiter_rr_picker.sv | 26 ++
 rtl/ptw_arbiter.sv | 139 +++++++++++++
 tb/tb_ptw_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_arb_pkg.sv
// Shared types and defaults for the page-table-walker arbiter.
package ptw_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int DEF_NUM_CLIENTS    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  function automatic int cli_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CLI_IDX_W = cli_idx_w(DEF_NUM_CLIENTS);

endpackage

// File: rtl/ptw_arbiter_rr_picker.sv
// Round-robin picker: first pending client after last_grant, wrapping.
module rr_picker
  import ptw_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int IW          = cli_idx_w(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] pending,
  input  logic [IW-1:0]          last_grant,
  output logic [IW-1:0]          grant,
  output logic                   grant_valid
);

  // Walk offsets from far to near so the nearest pending client is written last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = NUM_CLIENTS; i >= 1; i--) begin
      if (pending[(int'(last_grant) + i) % NUM_CLIENTS]) begin
        grant       = IW'((int'(last_grant) + i) % NUM_CLIENTS);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page table walker between TLB clients; one walk in flight,
// round-robin grant, timeout fault with drain of the late response.
//   state    | meaning
//   ST_IDLE  | no walk in flight, pick next pending client
//   ST_ISSUE | one-cycle ptw_req_o pulse
//   ST_WAIT  | waiting for PTW response, counting toward timeout
//   ST_DRAIN | timed out, swallowing the late response
module ptw_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = DEF_NUM_CLIENTS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CLIENTS-1:0]    cli_req_i,
  input  logic [NUM_CLIENTS*32-1:0] cli_vaddr_i,
  output logic [NUM_CLIENTS-1:0]    cli_resp_valid_o,
  output logic [NUM_CLIENTS-1:0]    cli_fault_o,
  output logic [31:0]               cli_pte_o,
  output logic                      ptw_req_o,
  output logic [31:0]               ptw_vaddr_o,
  input  logic                      ptw_resp_valid_i,
  input  logic [31:0]               ptw_pte_i,
  output logic                      busy_o
);

  localparam int          IW      = cli_idx_w(NUM_CLIENTS);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e                 state;
  logic [NUM_CLIENTS-1:0] pending;
  logic [31:0]            slot_addr [NUM_CLIENTS];
  logic [IW-1:0]          grant;
  logic [IW-1:0]          last_grant;
  logic [15:0]            cnt;

  logic [IW-1:0]          pick;
  logic                   pick_valid;
  logic [NUM_CLIENTS-1:0] grant_oh;
  logic                   resp_hit;
  logic                   timeout_hit;
  logic [NUM_CLIENTS-1:0] clr;
  logic [NUM_CLIENTS-1:0] capture;

  rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IW          (IW)
  ) u_rr_picker (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  always_comb begin
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
  end

  assign resp_hit    = (state == ST_WAIT) && ptw_resp_valid_i;
  assign timeout_hit = (state == ST_WAIT) && !ptw_resp_valid_i && (cnt == TO_LAST);
  assign clr         = (resp_hit || timeout_hit) ? grant_oh : '0;
  // A pulse landing on the clearing cycle re-arms the slot.
  assign capture     = cli_req_i & (~pending | clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | capture;
    end
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      if (capture[c]) slot_addr[c] <= cli_vaddr_i[32*c +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      grant            <= '0;
      last_grant       <= IW'(NUM_CLIENTS - 1);
      ptw_req_o        <= 1'b0;
      ptw_vaddr_o      <= '0;
      cli_resp_valid_o <= '0;
      cli_fault_o      <= '0;
      cli_pte_o        <= '0;
    end else begin
      ptw_req_o        <= 1'b0;
      cli_resp_valid_o <= '0;
      cli_fault_o      <= '0;
      cli_pte_o        <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant       <= pick;
            ptw_vaddr_o <= slot_addr[pick];
            ptw_req_o   <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ptw_resp_valid_i) begin
            cli_resp_valid_o <= grant_oh;
            cli_pte_o        <= ptw_pte_i;
            last_grant       <= grant;
            cnt              <= '0;
            state            <= ST_IDLE;
          end else if (cnt == TO_LAST) begin
            cli_resp_valid_o <= grant_oh;
            cli_fault_o      <= grant_oh;
            last_grant       <= grant;
            cnt              <= '0;
            state            <= ST_DRAIN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (ptw_resp_valid_i || cnt == TO_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_ptw_arbiter.sv
// Self-checking bench for ptw_arbiter: directed scenarios plus random traffic
// against a timestamp-based reference model.
module tb_ptw_arbiter;

  localparam int NC = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   cli_req;
  logic [NC*32-1:0] cli_vaddr;
  logic [NC-1:0]   cli_resp_valid_o;
  logic [NC-1:0]   cli_fault_o;
  logic [31:0]     cli_pte_o;
  logic            ptw_req_o;
  logic [31:0]     ptw_vaddr_o;
  logic            ptw_resp;
  logic [31:0]     ptw_pte;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          edge_n = 0;
  logic [NC-1:0] m_pend;
  logic [31:0] m_addr [NC];
  int          m_last;
  bit          m_busy, m_drain;
  int          m_g, m_d, m_cli;
  logic [31:0] m_vaddr;
  logic [NC-1:0] e_strobe, e_fault;
  logic [31:0] e_pte;
  bit          e_req, e_busy;

  ptw_arbiter #(.NUM_CLIENTS(NC), .TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .cli_req_i        (cli_req),
    .cli_vaddr_i      (cli_vaddr),
    .cli_resp_valid_o (cli_resp_valid_o),
    .cli_fault_o      (cli_fault_o),
    .cli_pte_o        (cli_pte_o),
    .ptw_req_o        (ptw_req_o),
    .ptw_vaddr_o      (ptw_vaddr_o),
    .ptw_resp_valid_i (ptw_resp),
    .ptw_pte_i        (ptw_pte),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: a walk granted at edge g has its WAIT window on edges g+2..g+1+TO;
  // a drain started at edge d ends on a response or at edge d+TO.
  task automatic model_edge();
    logic [NC-1:0] clr;
    logic [NC-1:0] old_pend;
    int c;
    edge_n++;
    e_strobe = '0; e_fault = '0; e_pte = '0; e_req = 1'b0;
    if (rst) begin
      m_pend = '0; m_last = NC - 1; m_busy = 1'b0; m_drain = 1'b0;
      m_vaddr = '0; e_busy = 1'b0;
      return;
    end
    clr = '0;
    old_pend = m_pend;
    if (m_busy && !m_drain) begin
      if (ptw_resp && edge_n >= m_g + 2) begin
        e_strobe[m_cli] = 1'b1; e_pte = ptw_pte;
        clr[m_cli] = 1'b1; m_last = m_cli; m_busy = 1'b0;
      end else if (edge_n == m_g + 1 + TO) begin
        e_strobe[m_cli] = 1'b1; e_fault[m_cli] = 1'b1;
        clr[m_cli] = 1'b1; m_last = m_cli; m_drain = 1'b1; m_d = edge_n;
      end
    end else if (m_drain) begin
      if (ptw_resp || edge_n == m_d + TO) begin
        m_drain = 1'b0; m_busy = 1'b0;
      end
    end else begin
      for (int i = 1; i <= NC; i++) begin
        c = (m_last + i) % NC;
        if (old_pend[c]) begin
          m_busy = 1'b1; m_g = edge_n; m_cli = c;
          m_vaddr = m_addr[c]; e_req = 1'b1;
          break;
        end
      end
    end
    for (int k = 0; k < NC; k++) begin
      if (clr[k]) m_pend[k] = 1'b0;
      if (cli_req[k] && (!old_pend[k] || clr[k])) begin
        m_pend[k] = 1'b1;
        m_addr[k] = cli_vaddr[32*k +: 32];
      end
    end
    e_busy = m_busy;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("resp_valid", 32'(cli_resp_valid_o), 32'(e_strobe));
    chk("fault",      32'(cli_fault_o),      32'(e_fault));
    chk("cli_pte",    cli_pte_o,             e_pte);
    chk("ptw_req",    32'(ptw_req_o),        32'(e_req));
    chk("ptw_vaddr",  ptw_vaddr_o,           m_vaddr);
    chk("busy",       32'(busy_o),           32'(e_busy));
  endtask

  task automatic do_reset();
    rst = 1'b1; cli_req = '0; ptw_resp = 1'b0; ptw_pte = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n_strobe, n_req;
    rst = 1'b1; cli_req = '0; cli_vaddr = '0; ptw_resp = 1'b0; ptw_pte = '0;
    m_pend = '0; m_last = NC - 1; m_busy = 1'b0; m_drain = 1'b0; m_vaddr = '0;
    m_g = 0; m_d = 0; m_cli = 0;

    // reset state
    do_reset();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_req",  32'(ptw_req_o), 32'd0);

    // single request from client 1 with fixed latencies
    cli_req = 2'b10; cli_vaddr[63:32] = 32'h0040_3123;
    step();
    cli_req = '0;
    step();
    chk("single_req",   32'(ptw_req_o), 32'd1);
    chk("single_vaddr", ptw_vaddr_o, 32'h0040_3123);
    repeat (4) step();
    ptw_resp = 1'b1; ptw_pte = 32'h1234_5003;
    step();
    ptw_resp = 1'b0;
    chk("single_strobe", 32'(cli_resp_valid_o), 32'h2);
    chk("single_pte",    cli_pte_o, 32'h1234_5003);

    // simultaneous pair, then a pair landing on client 1's clearing cycle
    do_reset();
    cli_req = 2'b11; cli_vaddr = {32'hA111_1000, 32'hA000_0000};
    step();
    cli_req = '0;
    step();
    chk("pair_first", ptw_vaddr_o, 32'hA000_0000);
    step();
    ptw_resp = 1'b1; ptw_pte = 32'h0000_0101;
    step();
    ptw_resp = 1'b0;
    chk("pair_strobe0", 32'(cli_resp_valid_o), 32'h1);
    step();
    chk("pair_second", ptw_vaddr_o, 32'hA111_1000);
    step();
    ptw_resp = 1'b1; ptw_pte = 32'h0000_0202;
    cli_req = 2'b11; cli_vaddr = {32'hB111_1000, 32'hB000_0000};
    step();
    ptw_resp = 1'b0; cli_req = '0;
    chk("pair_strobe1", 32'(cli_resp_valid_o), 32'h2);
    step();
    chk("pair2_first", ptw_vaddr_o, 32'hB000_0000);
    step();
    ptw_resp = 1'b1;
    step();
    ptw_resp = 1'b0;
    step();
    chk("pair2_second", ptw_vaddr_o, 32'hB111_1000);
    step();
    ptw_resp = 1'b1;
    step();
    ptw_resp = 1'b0;

    // timeout, then a late response swallowed in drain
    do_reset();
    cli_req = 2'b01; cli_vaddr[31:0] = 32'h0000_5000;
    step();
    cli_req = '0;
    step();
    chk("to_req", 32'(ptw_req_o), 32'd1);
    repeat (8) step();
    chk("to_early", 32'(cli_resp_valid_o), 32'd0);
    step();
    chk("to_strobe", 32'(cli_resp_valid_o), 32'h1);
    chk("to_fault",  32'(cli_fault_o), 32'h1);
    chk("to_pte",    cli_pte_o, 32'd0);
    repeat (3) step();
    chk("to_drain_busy", 32'(busy_o), 32'd1);
    ptw_resp = 1'b1; ptw_pte = 32'hDEAD_BEEF;
    step();
    ptw_resp = 1'b0;
    chk("to_late_strobe", 32'(cli_resp_valid_o), 32'd0);
    chk("to_idle",        32'(busy_o), 32'd0);

    // duplicate pulse while pending
    do_reset();
    cli_req = 2'b01; cli_vaddr[31:0] = 32'hAAAA_1000;
    step();
    cli_vaddr[31:0] = 32'hBBBB_2000;
    step();
    cli_req = '0;
    chk("dup_vaddr", ptw_vaddr_o, 32'hAAAA_1000);
    step();
    step();
    ptw_resp = 1'b1; ptw_pte = 32'h5555_0001;
    step();
    ptw_resp = 1'b0;
    chk("dup_strobe", 32'(cli_resp_valid_o), 32'h1);
    n_strobe = 0; n_req = 0;
    repeat (12) begin
      step();
      if (cli_resp_valid_o != '0) n_strobe++;
      if (ptw_req_o) n_req++;
    end
    chk("dup_extra_strobe", 32'(n_strobe), 32'd0);
    chk("dup_extra_req",    32'(n_req), 32'd0);

    // reset mid-walk, then a stray response
    do_reset();
    cli_req = 2'b10; cli_vaddr[63:32] = 32'h0777_0000;
    step();
    cli_req = '0;
    repeat (3) step();
    chk("rstw_busy_pre", 32'(busy_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; ptw_resp = 1'b1; ptw_pte = 32'hCAFE_0001;
    step();
    ptw_resp = 1'b0;
    chk("rstw_strobe", 32'(cli_resp_valid_o), 32'd0);
    chk("rstw_busy",   32'(busy_o), 32'd0);
    chk("rstw_vaddr",  ptw_vaddr_o, 32'd0);
    n_req = 0;
    repeat (5) begin
      step();
      if (ptw_req_o || cli_resp_valid_o != '0) n_req++;
    end
    chk("rstw_quiet", 32'(n_req), 32'd0);

    // random traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < NC; k++) cli_req[k] = ($urandom_range(0, 7) == 0);
      cli_vaddr = {$urandom, $urandom};
      ptw_resp  = ($urandom_range(0, 4) == 0);
      ptw_pte   = $urandom;
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; cli_req = '0; ptw_resp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
